// File: rtl/fixed_point_multiplier_if.sv
// Start/busy/done handshake and operand/result bus for the fixed-point multiplier.
interface fixed_point_multiplier_if #(
   parameter int unsigned N = 10
);
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         ovf;

   modport master (output start, a, b, input busy, done, result, ovf);
   modport slave  (input start, a, b, output busy, done, result, ovf);
endinterface

// File: rtl/fixed_point_multiplier.sv
// Sequential unsigned QN-F.F multiplier: radix-2 shift-and-add, one multiplier bit per cycle.
module fixed_point_multiplier #(
   parameter int unsigned N = 10,
   parameter int unsigned F = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   fixed_point_multiplier_if.slave bus
);
   localparam int unsigned CW = $clog2(N + 1);
   localparam int unsigned PW = 2 * N;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N-1:0]    r_mcand;
   logic [N-1:0]    r_mplier;
   logic [N-1:0]    r_acc;
   logic [CW-1:0]   r_cnt;
   logic [N-1:0]    r_result;
   logic            r_ovf;
   logic            r_busy;
   logic            r_done;
   logic [N:0]      w_sum;
   logic [PW-1:0]   w_prod;
   logic            w_last;

   // Conditional add, then shift {carry, acc, multiplier} right by one.
   assign w_sum  = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
   assign w_prod = PW'({w_sum, r_mplier} >> 1);
   assign w_last = (r_cnt == CW'(N - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_CALC;
         S_CALC:  if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_busy <= (w_state_nxt != S_IDLE);
         r_done <= (w_state_nxt == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_mcand  <= bus.a;
                  r_mplier <= bus.b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            S_CALC: begin
               r_acc    <= w_prod[PW-1:N];
               r_mplier <= w_prod[N-1:0];
               r_cnt    <= r_cnt + CW'(1);
               // Product complete on the last iteration: truncate and flag integer overflow.
               if (w_last) begin
                  r_result <= w_prod[N+F-1:F];
                  r_ovf    <= ((w_prod >> (N + F)) != '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_fixed_point_multiplier.sv
// Self-checking bench for fixed_point_multiplier: directed cases, handshake, async reset, random ops.
module tb_fixed_point_multiplier;
   localparam int unsigned N = 10;
   localparam int unsigned F = 5;

   logic clk;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   fixed_point_multiplier_if #(.N(N)) bus ();

   fixed_point_multiplier #(.N(N), .F(F)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reference: full product, shift out F fraction bits, {ovf, low N bits}.
   function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
      longint unsigned p;
      longint unsigned q;
      p = longint'(x) * longint'(y);
      q = p >> F;
      return {((q >> N) != 0), N'(q)};
   endfunction

   // Issue one operation from a negedge in IDLE; returns at the negedge after DONE->IDLE.
   task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                        input bit scramble);
      logic [N:0] exp;
      int lat;
      int busy_cyc;
      bit got;
      exp = model(ta, tb_);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_;
      @(posedge clk);
      #1 bus.start = 1'b0;
      got = 0; lat = 0; busy_cyc = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (bus.busy) busy_cyc++;
         if (bus.done) begin
            got = 1;
            lat = cyc - 1;
            bus.start = 1'b0;
            break;
         end
         if (scramble) begin
            bus.a     = N'($urandom);
            bus.b     = N'($urandom);
            bus.start = (cyc <= int'(N)) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      bus.start = 1'b0;
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      check({tag, "_latency"}, 32'(lat), 32'(N));
      check({tag, "_result"}, 32'(bus.result), 32'(exp[N-1:0]));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp[N]));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, "_busy_cycles"}, 32'(busy_cyc + int'(bus.busy)), 32'(N + 1));
   endtask

   initial begin
      logic [N:0] exp_q;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      #3;
      check("rst_busy",   32'(bus.busy),   32'd0);
      check("rst_done",   32'(bus.done),   32'd0);
      check("rst_result", 32'(bus.result), 32'd0);
      check("rst_ovf",    32'(bus.ovf),    32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      do_op("basic",   N'('h050), N'('h030), 1'b0);
      do_op("trunc",   N'('h001), N'('h001), 1'b0);
      do_op("zero",    N'('h000), N'('h3FF), 1'b0);
      do_op("ovf16x2", N'('h200), N'('h040), 1'b0);
      do_op("ovfmax",  N'('h3FF), N'('h3FF), 1'b0);
      check("max_value", 32'(bus.result), 32'h3C0);

      // start held high: accepts every N+2 cycles, operands mid-CALC ignored
      bus.start = 1'b1;
      exp_q = '0;
      for (int p = 0; p < 3 * int'(N + 2); p++) begin
         bus.a = N'($urandom);
         bus.b = N'($urandom);
         if (p % int'(N + 2) == 0) exp_q = model(bus.a, bus.b);
         if (p == 3 * int'(N + 2) - 1) bus.start = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("hold_done", 32'(bus.done), 32'(p % int'(N + 2) == int'(N)));
         check("hold_busy", 32'(bus.busy), 32'(p % int'(N + 2) != int'(N + 1)));
         if (p % int'(N + 2) == int'(N)) begin
            check("hold_result", 32'(bus.result), 32'(exp_q[N-1:0]));
            check("hold_ovf",    32'(bus.ovf),    32'(exp_q[N]));
         end
      end
      bus.start = 1'b0;
      @(negedge clk);

      // async reset during iteration 5
      bus.start = 1'b1;
      bus.a = N'('h3FF);
      bus.b = N'('h3FF);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("midrst_busy",   32'(bus.busy),   32'd0);
      check("midrst_done",   32'(bus.done),   32'd0);
      check("midrst_result", 32'(bus.result), 32'd0);
      check("midrst_ovf",    32'(bus.ovf),    32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      do_op("after_rst", N'('h020), N'('h0A0), 1'b0);
      check("after_rst_val", 32'(bus.result), 32'h0A0);

      // random operands, random gaps, operand/start noise during CALC
      for (int i = 0; i < 1000; i++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         repeat (gap) @(negedge clk);
         do_op("rand", N'($urandom), N'($urandom), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
